dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the configuration inputs of the DDS top (dds_en, wav_select, freq_ctrl, phase_ctrl, amp_ctrl). It takes a start/stop/step/dwell programme and steps freq_ctrl linearly between the endpoints. Three sweep modes: single, repeat and ping-pong. It sits between the register/host interface and the DDS top. It owns all DDS control inputs while a sweep is active.

---
 rtl/dds_pkg.sv | 30 +++
 rtl/dds_sweep_ctrl_if.sv | 63 ++++++
 rtl/dds_sweep_step.sv | 50 +++++
 rtl/dds_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared types and defaults for the DDS sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int FREQ_W_DEF   = 26;
    localparam int PHASE_W_DEF  = 9;
    localparam int DATA_BIT_DEF = 14;
    localparam int DWELL_W_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    // Encoding 3 is reserved and behaves as a single sweep.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? MODE_SINGLE : mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl_if
//  Description : Host-side programme/command bus and DDS control outputs.
//                Marker signals present only with DDS_SWEEP_MARKER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int DATA_BIT = DATA_BIT_DEF,
    parameter int DWELL_W  = DWELL_W_DEF
);
    logic                start;
    logic                abort;
    logic [1:0]          cfg_mode;
    logic [FREQ_W-1:0]   cfg_start_freq;
    logic [FREQ_W-1:0]   cfg_stop_freq;
    logic [FREQ_W-1:0]   cfg_step;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic [1:0]          cfg_wav_select;
    logic [PHASE_W-1:0]  cfg_phase;
    logic [DATA_BIT-1:0] cfg_amp;

    logic                dds_en;
    logic [1:0]          wav_select;
    logic [FREQ_W-1:0]   freq_ctrl;
    logic [PHASE_W-1:0]  phase_ctrl;
    logic [DATA_BIT-1:0] amp_ctrl;
    logic                busy;
    logic                step_pulse;
    logic                done_pulse;
`ifdef DDS_SWEEP_MARKER_EN
    logic [FREQ_W-1:0]   cfg_marker_freq;
    logic                marker;
`endif

    modport master (
`ifdef DDS_SWEEP_MARKER_EN
        output cfg_marker_freq,
        input  marker,
`endif
        output start, abort, cfg_mode, cfg_start_freq, cfg_stop_freq, cfg_step,
               cfg_dwell, cfg_wav_select, cfg_phase, cfg_amp,
        input  dds_en, wav_select, freq_ctrl, phase_ctrl, amp_ctrl, busy,
               step_pulse, done_pulse
    );

    modport slave (
`ifdef DDS_SWEEP_MARKER_EN
        input  cfg_marker_freq,
        output marker,
`endif
        input  start, abort, cfg_mode, cfg_start_freq, cfg_stop_freq, cfg_step,
               cfg_dwell, cfg_wav_select, cfg_phase, cfg_amp,
        output dds_en, wav_select, freq_ctrl, phase_ctrl, amp_ctrl, busy,
               step_pulse, done_pulse
    );

endinterface
`default_nettype wire

// File: rtl/dds_sweep_step.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_step
//  Description : Combinational next-point compute: step, clamp to the active
//                endpoint, end-reached flag and ping-pong turn direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_step
    import dds_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF
)(
    input  wire [FREQ_W-1:0] i_freq,
    input  wire [FREQ_W-1:0] i_step,
    input  wire [FREQ_W-1:0] i_stop_freq,
    input  wire [FREQ_W-1:0] i_turn_freq,
    input  wire              i_dir_up,
    input  wire              i_pingpong,
    output logic [FREQ_W-1:0] o_next_freq,
    output logic             o_at_end,
    output logic             o_next_dir_up
);
    logic              w_turn;
    logic              w_up;
    logic [FREQ_W-1:0] w_lim;
    logic [FREQ_W:0]   w_sum;
    logic [FREQ_W:0]   w_diff;

    // A zero step can never move, so it counts as already at the end.
    assign o_at_end      = (i_freq == i_stop_freq) || (i_step == '0);
    assign w_turn        = o_at_end && i_pingpong;
    assign w_up          = i_dir_up ^ w_turn;
    assign w_lim         = w_turn ? i_turn_freq : i_stop_freq;
    assign o_next_dir_up = w_up;

    assign w_sum  = {1'b0, i_freq} + {1'b0, i_step};
    assign w_diff = {1'b0, i_freq} - {1'b0, i_step};

    always_comb begin
        o_next_freq = i_freq;
        if (w_up) begin
            o_next_freq = (w_sum >= {1'b0, w_lim}) ? w_lim : w_sum[FREQ_W-1:0];
        end else begin
            o_next_freq = (w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] <= w_lim))
                        ? w_lim : w_diff[FREQ_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl
//  Description : Linear frequency-sweep sequencer driving the DDS controls
//                (single / repeat / ping-pong). Option: DDS_SWEEP_MARKER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int DATA_BIT = DATA_BIT_DEF,
    parameter int DWELL_W  = DWELL_W_DEF
)(
    input  wire             sclk,
    input  wire             rst,
    dds_sweep_ctrl_if.slave bus
);
    sweep_state_t        r_state;
    logic [1:0]          r_mode;
    logic [FREQ_W-1:0]   r_start_freq;
    logic [FREQ_W-1:0]   r_stop_act;
    logic [FREQ_W-1:0]   r_turn_act;
    logic [FREQ_W-1:0]   r_step;
    logic                r_dir_up;
    logic [DWELL_W-1:0]  r_dwell_rld;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [FREQ_W-1:0]   r_freq;
    logic                r_dds_en;
    logic [1:0]          r_wav;
    logic [PHASE_W-1:0]  r_phase;
    logic [DATA_BIT-1:0] r_amp;
    logic                r_busy;
    logic                r_step_pulse;
    logic                r_done_pulse;

    logic [FREQ_W-1:0]   w_next_freq;
    logic                w_at_end;
    logic                w_next_dir_up;
    logic                w_pingpong;
    logic [DWELL_W-1:0]  w_dwell_rld;

    assign w_pingpong  = (r_mode == MODE_PINGPONG);
    assign w_dwell_rld = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - DWELL_W'(1);

    dds_sweep_step #(.FREQ_W(FREQ_W)) u_step (
        .i_freq        (r_freq),
        .i_step        (r_step),
        .i_stop_freq   (r_stop_act),
        .i_turn_freq   (r_turn_act),
        .i_dir_up      (r_dir_up),
        .i_pingpong    (w_pingpong),
        .o_next_freq   (w_next_freq),
        .o_at_end      (w_at_end),
        .o_next_dir_up (w_next_dir_up)
    );

`ifdef DDS_SWEEP_MARKER_EN
    logic [FREQ_W-1:0] r_marker_freq;
    logic              r_marker_armed;
    logic              r_marker;

    function automatic logic marker_hit(input logic [FREQ_W-1:0] p,
                                        input logic [FREQ_W-1:0] m,
                                        input logic              up);
        return up ? (p >= m) : (p <= m);
    endfunction

    assign bus.marker = r_marker;
`endif

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mode       <= MODE_SINGLE;
            r_start_freq <= '0;
            r_stop_act   <= '0;
            r_turn_act   <= '0;
            r_step       <= '0;
            r_dir_up     <= 1'b0;
            r_dwell_rld  <= '0;
            r_dwell_cnt  <= '0;
            r_freq       <= '0;
            r_dds_en     <= 1'b0;
            r_wav        <= '0;
            r_phase      <= '0;
            r_amp        <= '0;
            r_busy       <= 1'b0;
            r_step_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
`ifdef DDS_SWEEP_MARKER_EN
            r_marker_freq  <= '0;
            r_marker_armed <= 1'b0;
            r_marker       <= 1'b0;
`endif
        end else begin
            r_step_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
`ifdef DDS_SWEEP_MARKER_EN
            r_marker     <= 1'b0;
`endif
            if (bus.abort) begin
                r_state  <= IDLE;
                r_dds_en <= 1'b0;
                r_freq   <= '0;
                r_wav    <= '0;
                r_phase  <= '0;
                r_amp    <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            r_state      <= RUN;
                            r_mode       <= norm_mode(bus.cfg_mode);
                            r_start_freq <= bus.cfg_start_freq;
                            r_stop_act   <= bus.cfg_stop_freq;
                            r_turn_act   <= bus.cfg_start_freq;
                            r_step       <= bus.cfg_step;
                            r_dir_up     <= (bus.cfg_start_freq <= bus.cfg_stop_freq);
                            r_dwell_rld  <= w_dwell_rld;
                            r_dwell_cnt  <= w_dwell_rld;
                            r_freq       <= bus.cfg_start_freq;
                            r_dds_en     <= 1'b1;
                            r_wav        <= bus.cfg_wav_select;
                            r_phase      <= bus.cfg_phase;
                            r_amp        <= bus.cfg_amp;
                            r_busy       <= 1'b1;
                            r_step_pulse <= 1'b1;
`ifdef DDS_SWEEP_MARKER_EN
                            r_marker_freq  <= bus.cfg_marker_freq;
                            r_marker       <= marker_hit(bus.cfg_start_freq, bus.cfg_marker_freq,
                                                         bus.cfg_start_freq <= bus.cfg_stop_freq);
                            r_marker_armed <= !marker_hit(bus.cfg_start_freq, bus.cfg_marker_freq,
                                                          bus.cfg_start_freq <= bus.cfg_stop_freq);
`endif
                        end
                    end
                    RUN: begin
                        if (r_dwell_cnt != '0) begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end else if (w_at_end && (r_mode == MODE_SINGLE)) begin
                            r_state      <= DONE;
                            r_busy       <= 1'b0;
                            r_done_pulse <= 1'b1;
                        end else if (w_at_end && (r_mode == MODE_REPEAT)) begin
                            r_freq       <= r_start_freq;
                            r_step_pulse <= 1'b1;
                            r_dwell_cnt  <= r_dwell_rld;
`ifdef DDS_SWEEP_MARKER_EN
                            r_marker       <= marker_hit(r_start_freq, r_marker_freq, r_dir_up);
                            r_marker_armed <= !marker_hit(r_start_freq, r_marker_freq, r_dir_up);
`endif
                        end else begin
                            // Ping-pong turns here: endpoints swap, step taken from the current point.
                            r_freq       <= w_next_freq;
                            r_step_pulse <= 1'b1;
                            r_dwell_cnt  <= r_dwell_rld;
                            r_dir_up     <= w_next_dir_up;
                            if (w_at_end) begin
                                r_stop_act <= r_turn_act;
                                r_turn_act <= r_stop_act;
                            end
`ifdef DDS_SWEEP_MARKER_EN
                            r_marker       <= (r_marker_armed || w_at_end) &&
                                              marker_hit(w_next_freq, r_marker_freq, w_next_dir_up);
                            r_marker_armed <= (r_marker_armed || w_at_end) &&
                                              !marker_hit(w_next_freq, r_marker_freq, w_next_dir_up);
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dds_en     = r_dds_en;
    assign bus.wav_select = r_wav;
    assign bus.freq_ctrl  = r_freq;
    assign bus.phase_ctrl = r_phase;
    assign bus.amp_ctrl   = r_amp;
    assign bus.busy       = r_busy;
    assign bus.step_pulse = r_step_pulse;
    assign bus.done_pulse = r_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_sweep_ctrl
//  Description : Scoreboard bench for dds_sweep_ctrl against a point-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    localparam int FW = 26;
    localparam int PW = 9;
    localparam int DB = 14;
    localparam int DW = 24;

    typedef struct packed {
        logic          en;
        logic [1:0]    wav;
        logic [FW-1:0] freq;
        logic [PW-1:0] ph;
        logic [DB-1:0] amp;
        logic          busy;
        logic          sp;
        logic          dp;
    } out_t;

    typedef struct {
        int     mode;
        longint sf;
        longint ef;
        longint step;
        int     dwell;
        int     wav;
        int     ph;
        int     amp;
    } prog_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    dds_sweep_ctrl_if #(.FREQ_W(FW), .PHASE_W(PW), .DATA_BIT(DB), .DWELL_W(DW)) bus ();

    dds_sweep_ctrl #(.FREQ_W(FW), .PHASE_W(PW), .DATA_BIT(DB), .DWELL_W(DW)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    out_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    string tname  = "reset";

    // ---------------- reference model ----------------
    int    mstate = 0;          // 0 idle, 1 sweeping, 2 finished
    out_t  tl[$];               // expected outputs, one per cycle of the sweep
    out_t  last_o;
    prog_t p;

    function automatic out_t mk(prog_t pr, longint f, bit busy, bit sp, bit dp);
        out_t o;
        o.en   = 1'b1;
        o.wav  = 2'(pr.wav);
        o.freq = FW'(f);
        o.ph   = PW'(pr.ph);
        o.amp  = DB'(pr.amp);
        o.busy = busy;
        o.sp   = sp;
        o.dp   = dp;
        return o;
    endfunction

    function automatic longint mv(longint cur, longint step, longint tgt, bit up);
        longint n;
        if (up) begin
            n = cur + step;
            return (n >= tgt) ? tgt : n;
        end
        n = cur - step;
        return (n <= tgt) ? tgt : n;
    endfunction

    function automatic void gen(prog_t pr);
        longint cur = pr.sf, tgt = pr.ef, oth = pr.sf, t;
        bit     up  = (pr.sf <= pr.ef);
        int     d   = (pr.dwell == 0) ? 1 : pr.dwell;
        int     md  = (pr.mode == 3) ? 0 : pr.mode;
        bit     fin = 0;
        tl.delete();
        while (!fin && tl.size() < 400) begin
            for (int i = 0; i < d; i++) tl.push_back(mk(pr, cur, 1'b1, i == 0, 1'b0));
            if (cur == tgt || pr.step == 0) begin
                if (md == 0) begin
                    tl.push_back(mk(pr, cur, 1'b0, 1'b0, 1'b1));
                    fin = 1;
                end else if (md == 1) begin
                    cur = pr.sf;
                end else begin
                    t = tgt; tgt = oth; oth = t; up = !up;
                    cur = mv(cur, pr.step, tgt, up);
                end
            end else begin
                cur = mv(cur, pr.step, tgt, up);
            end
        end
    endfunction

    function automatic out_t model(bit s, bit a, bit r, prog_t pr);
        out_t o;
        if (r || a) begin
            mstate = 0;
            return '0;
        end
        if (s && mstate != 1) begin
            gen(pr);
            mstate = 1;
        end
        if (mstate == 1) begin
            o = tl.pop_front();
            if (o.dp) mstate = 2;
            last_o = o;
            return o;
        end
        if (mstate == 2) begin
            o = last_o;
            o.sp = 1'b0;
            o.dp = 1'b0;
            return o;
        end
        return '0;
    endfunction

    // ---------------- monitor ----------------
    out_t  m_e, m_a;
    string m_n;
    always @(negedge sclk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_n = name_q.pop_front();
            m_a = {bus.dds_en, bus.wav_select, bus.freq_ctrl, bus.phase_ctrl,
                   bus.amp_ctrl, bus.busy, bus.step_pulse, bus.done_pulse};
            n_chk++;
            if (m_a !== m_e) begin
                n_fail++;
                $display("FAIL %s @%0t: got en=%b wav=%0d freq=%h ph=%h amp=%h busy=%b sp=%b dp=%b, required en=%b wav=%0d freq=%h ph=%h amp=%h busy=%b sp=%b dp=%b",
                         m_n, $time, m_a.en, m_a.wav, m_a.freq, m_a.ph, m_a.amp, m_a.busy, m_a.sp, m_a.dp,
                         m_e.en, m_e.wav, m_e.freq, m_e.ph, m_e.amp, m_e.busy, m_e.sp, m_e.dp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(bit s, bit a, bit r);
        @(negedge sclk);
        #1;
        rst                = r;
        bus.start          = s;
        bus.abort          = a;
        bus.cfg_mode       = 2'(p.mode);
        bus.cfg_start_freq = FW'(p.sf);
        bus.cfg_stop_freq  = FW'(p.ef);
        bus.cfg_step       = FW'(p.step);
        bus.cfg_dwell      = DW'(p.dwell);
        bus.cfg_wav_select = 2'(p.wav);
        bus.cfg_phase      = PW'(p.ph);
        bus.cfg_amp        = DB'(p.amp);
        exp_q.push_back(model(s, a, r, p));
        name_q.push_back(tname);
    endtask

    task automatic run(int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic setp(int mode, longint sf, longint ef, longint step, int dwell);
        p.mode = mode; p.sf = sf; p.ef = ef; p.step = step; p.dwell = dwell;
        p.wav = int'($urandom_range(0, 3));
        p.ph  = int'($urandom_range(0, 511));
        p.amp = int'($urandom_range(0, 16383));
    endtask

    task automatic randp();
        setp(int'($urandom_range(0, 3)), longint'($urandom_range(0, 60)),
             longint'($urandom_range(0, 60)), longint'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
        if ($urandom_range(0, 7) == 0) begin
            p.sf = longint'($urandom & 32'h03FF_FFFF);
            p.ef = longint'($urandom & 32'h03FF_FFFF);
            p.step = longint'($urandom & 32'h03FF_FFFF);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        setp(0, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        run(2);

        tname = "single";
        setp(0, 100, 130, 10, 3);
        cyc(1'b1, 1'b0, 1'b0);
        run(16);

        tname = "clamp";
        setp(0, 100, 125, 10, 1);
        cyc(1'b1, 1'b0, 1'b0);
        run(8);

        tname = "pingpong_up";
        setp(2, 0, 20, 10, 1);
        cyc(1'b1, 1'b0, 1'b0);
        run(10);
        cyc(1'b0, 1'b1, 1'b0);
        tname = "pingpong_down";
        setp(2, 20, 0, 10, 1);
        cyc(1'b1, 1'b0, 1'b0);
        run(8);
        cyc(1'b0, 1'b1, 1'b0);

        tname = "repeat_abort";
        setp(1, 5, 7, 1, 2);
        cyc(1'b1, 1'b0, 1'b0);
        run(8);
        cyc(1'b0, 1'b1, 1'b0);
        run(2);

        tname = "dwell0";
        setp(0, 10, 30, 10, 0);
        cyc(1'b1, 1'b0, 1'b0);
        run(6);

        tname = "step0_single";
        setp(0, 50, 90, 0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        run(5);

        tname = "start_in_run";
        setp(0, 0, 40, 10, 2);
        cyc(1'b1, 1'b0, 1'b0);
        run(3);
        setp(1, 900, 901, 1, 1);
        cyc(1'b1, 1'b0, 1'b0);
        setp(0, 0, 40, 10, 2);
        run(10);

        tname = "start_abort_idle";
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        run(2);

        tname = "overflow";
        setp(0, 64'h3FF_FFF0, 64'h3FF_FFFF, 64'h20, 1);
        cyc(1'b1, 1'b0, 1'b0);
        run(4);

        tname = "rst_mid";
        setp(1, 0, 100, 3, 1);
        cyc(1'b1, 1'b0, 1'b0);
        run(5);
        cyc(1'b0, 1'b0, 1'b1);
        run(2);

        tname = "random";
        for (int it = 0; it < 60; it++) begin
            randp();
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < int'($urandom_range(5, 40)); k++) begin
                int r = int'($urandom_range(0, 99));
                if ($urandom_range(0, 9) == 0) randp();
                cyc(r < 6, (r >= 6) && (r < 9), r == 9);
            end
        end

        tname = "drain";
        repeat (3) @(negedge sclk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
